// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream boot loader that fills the CPU instruction memory, then enables the CPU
// Optional trailing XOR checksum byte is enabled by defining IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int          IMEM_WORDS  = 128,
  parameter logic [63:0] ADDR_OFFSET = 64'd0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERROR, S_CHK} state_t;
  localparam state_t S_FINAL = S_CHK;
  logic [7:0] r_csum;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE, S_ERROR} state_t;
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [1:0]  r_lane;
  logic [23:0] r_bytes;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cpu_enable;

  logic        w_active;
  logic        w_accept;
  logic [15:0] w_hdr_n;
  logic        w_last_word;
  logic [63:0] w_word_addr;

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  assign w_active = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                    (r_state == S_DATA) || (r_state == S_CHK);
`else
  assign w_active = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
`endif

  assign w_accept    = in_valid && w_active;
  assign w_hdr_n     = {in_data, r_count[7:0]};
  assign w_last_word = (r_index == r_count - 16'd1);
  assign w_word_addr = ADDR_OFFSET + {46'd0, r_index, 2'b00};

  assign in_ready   = w_active;
  assign busy       = w_active;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign wen_ext    = r_wen;
  assign addr_ext   = r_addr;
  assign wdata_ext  = r_wdata;
  assign ren_ext    = 1'b0;
  assign cpu_enable = r_cpu_enable;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_index      <= '0;
      r_lane       <= '0;
      r_bytes      <= '0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_enable <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_wen <= 1'b0;
      // Enable trails DONE by one cycle so the last write has landed first.
      r_cpu_enable <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: if (start) r_state <= S_HDR0;
        S_HDR0: if (w_accept) begin
          r_count[7:0] <= in_data;
          r_state      <= S_HDR1;
        end
        S_HDR1: if (w_accept) begin
          r_count[15:8] <= in_data;
          if ({1'b0, w_hdr_n} > MAX_N) r_state <= S_ERROR;
          else if (w_hdr_n == 16'd0)   r_state <= S_FINAL;
          else                         r_state <= S_DATA;
        end
        S_DATA: if (w_accept) begin
          r_lane <= r_lane + 2'd1;
          if (r_lane == 2'd3) begin
            r_wen   <= 1'b1;
            r_addr  <= w_word_addr;
            r_wdata <= {in_data, r_bytes};
            r_index <= r_index + 16'd1;
            if (w_last_word) r_state <= S_FINAL;
          end else begin
            case (r_lane)
              2'd0:    r_bytes[7:0]   <= in_data;
              2'd1:    r_bytes[15:8]  <= in_data;
              default: r_bytes[23:16] <= in_data;
            endcase
          end
        end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        S_CHK: if (w_accept) r_state <= (in_data == r_csum) ? S_DONE : S_ERROR;
`endif
        S_DONE, S_ERROR: if (start) begin
          r_state      <= S_HDR0;
          r_count      <= '0;
          r_index      <= '0;
          r_lane       <= '0;
          r_cpu_enable <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
          r_csum       <= '0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      if (w_accept && (r_state != S_CHK)) r_csum <= r_csum ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed vector table plus hand-written sequences for imem_boot_loader
`timescale 1ns/1ps
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wen_ext, ren_ext, cpu_enable, busy, done, error;
  logic [63:0] addr_ext;
  logic [31:0] wdata_ext;

  imem_boot_loader #(.IMEM_WORDS(128), .ADDR_OFFSET(64'd0)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s, v;
    logic [7:0]  d;
    logic        rdy, wen;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        en, dn, er, bz;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] img[$];
  bit          watch_busy = 0;
  int          busy_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wen_ext) begin
      wa_q.push_back(addr_ext);
      wd_q.push_back(wdata_ext);
    end
    if (watch_busy && !busy) busy_drops++;
  endtask

  function automatic void addv(logic s, logic v, logic [7:0] d, logic rdy, logic wen,
                               logic [63:0] a, logic [31:0] wd, logic en, logic dn,
                               logic er, logic bz);
    vecs.push_back('{s, v, d, rdy, wen, a, wd, en, dn, er, bz});
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit slow);
    bit acc = 0;
    for (int c = 0; c < 300 && !acc; c++) begin
      in_valid = slow ? ($urandom_range(0, 99) < 30) : 1'b1;
      in_data  = b;
      acc      = in_valid && in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic load_image(input bit slow, input bit do_start);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  b;
    n = 16'(img.size());
    wa_q.delete();
    wd_q.delete();
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    watch_busy = 1;
    cs = n[7:0] ^ n[15:8];
    send_byte(n[7:0], slow);
    send_byte(n[15:8], slow);
    for (int i = 0; i < img.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = img[i][8*k +: 8];
        cs = cs ^ b;
`ifndef IMEM_BOOT_LOADER_CHECKSUM_EN
        if (i == img.size() - 1 && k == 3) watch_busy = 0;
`endif
        send_byte(b, slow);
      end
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    watch_busy = 0;
    send_byte(cs, slow);
`endif
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_npulses"}, 64'(wa_q.size()), 64'(img.size()));
    for (int i = 0; i < img.size() && i < wa_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa_q[i], 64'(4 * i));
      check($sformatf("%s_data%0d", tag, i), 64'(wd_q[i]), 64'(img[i]));
    end
  endtask

  initial begin
    // start coincident with reset must be ignored
    arst_n = 1'b0;
    start  = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_wen", 64'(wen_ext), 64'd0);
    check("rst_addr", addr_ext, 64'd0);
    check("rst_wdata", 64'(wdata_ext), 64'd0);
    check("rst_flags", {60'd0, cpu_enable, done, error, busy}, 64'd0);
    check("ren_tied", 64'(ren_ext), 64'd0);
    arst_n = 1'b1;
    tick();
    check("idle_ready", 64'(in_ready), 64'd0);

    // image 02 00 13 00 00 00 93 00 10 00, start pulse ignored mid-load, one stall cycle
    addv(1, 0, 8'h00, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(0, 1, 8'h02, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(0, 1, 8'h00, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(0, 1, 8'h13, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(1, 1, 8'h00, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(0, 1, 8'h00, 1, 0, 64'h0, 32'h0,        0, 0, 0, 1);
    addv(0, 1, 8'h00, 1, 1, 64'h0, 32'h00000013, 0, 0, 0, 1);
    addv(0, 1, 8'h93, 1, 0, 64'h0, 32'h00000013, 0, 0, 0, 1);
    addv(0, 0, 8'h55, 1, 0, 64'h0, 32'h00000013, 0, 0, 0, 1);
    addv(0, 1, 8'h00, 1, 0, 64'h0, 32'h00000013, 0, 0, 0, 1);
    addv(0, 1, 8'h10, 1, 0, 64'h0, 32'h00000013, 0, 0, 0, 1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    addv(0, 1, 8'h00, 1, 1, 64'h4, 32'h00100093, 0, 0, 0, 1);
    addv(0, 1, 8'h92, 0, 0, 64'h4, 32'h00100093, 0, 1, 0, 0);
`else
    addv(0, 1, 8'h00, 0, 1, 64'h4, 32'h00100093, 0, 1, 0, 0);
`endif
    addv(0, 0, 8'h00, 0, 0, 64'h4, 32'h00100093, 1, 1, 0, 0);
    addv(0, 0, 8'h00, 0, 0, 64'h4, 32'h00100093, 1, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start    = vecs[i].s;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      check($sformatf("v%0d_ready", i), 64'(in_ready), 64'(vecs[i].rdy));
      check($sformatf("v%0d_wen", i), 64'(wen_ext), 64'(vecs[i].wen));
      check($sformatf("v%0d_addr", i), addr_ext, vecs[i].addr);
      check($sformatf("v%0d_wdata", i), 64'(wdata_ext), 64'(vecs[i].wdata));
      check($sformatf("v%0d_en_dn_er_bz", i), {60'd0, cpu_enable, done, error, busy},
            {60'd0, vecs[i].en, vecs[i].dn, vecs[i].er, vecs[i].bz});
    end

    // re-arm from DONE, then overwrite memory from address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rearm_en", 64'(cpu_enable), 64'd0);
    check("rearm_hdr0", {62'd0, in_ready, done}, {62'd0, 1'b1, 1'b0});
    img = '{32'hDEADBEEF, 32'h00000073};
    load_image(0, 0);
    check_writes("overwrite");
    tick();
    tick();
    check("overwrite_en", {62'd0, cpu_enable, done}, {62'd0, 1'b1, 1'b1});

    // N == 0
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    check("n0_chk_state", {62'd0, busy, done}, {62'd0, 1'b1, 1'b0});
    send_byte(8'h00, 0);
`endif
    check("n0_done", {62'd0, done, cpu_enable}, {62'd0, 1'b1, 1'b0});
    tick();
    check("n0_en", 64'(cpu_enable), 64'd1);

    // header count 0x0081 exceeds capacity
    wa_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h81, 0);
    send_byte(8'h00, 0);
    check("ovf_error", {61'd0, error, in_ready, cpu_enable}, {61'd0, 1'b1, 1'b0, 1'b0});
    tick();
    tick();
    check("ovf_hold", {62'd0, error, cpu_enable}, {62'd0, 1'b1, 1'b0});
    check("ovf_nowrite", 64'(wa_q.size()), 64'd0);

    // 4-word image with in_valid at ~30% duty
    img = '{32'h11223344, 32'hA5A55A5A, 32'h00000000, 32'hFFFFFFFF};
    busy_drops = 0;
    load_image(1, 1);
    check("slow_busy_drops", 64'(busy_drops), 64'd0);
    check_writes("slow");
    tick();
    check("slow_en", 64'(cpu_enable), 64'd1);

    // reset after 6 payload bytes
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 6; k++) send_byte(8'(k + 1), 0);
    arst_n = 1'b0;
    tick();
    check("midrst_ready_wen", {62'd0, in_ready, wen_ext}, 64'd0);
    check("midrst_addr", addr_ext, 64'd0);
    check("midrst_wdata", 64'(wdata_ext), 64'd0);
    check("midrst_flags", {60'd0, cpu_enable, done, error, busy}, 64'd0);
    check("midrst_writes", 64'(wa_q.size()), 64'd1);
    arst_n = 1'b1;
    img = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
    load_image(0, 1);
    check_writes("reload");
    tick();
    check("reload_en", 64'(cpu_enable), 64'd1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // stream 01 00 13 00 00 00 12 -> DONE
    img = '{32'h00000013};
    load_image(0, 1);
    check("chk_ok_done", {62'd0, done, error}, {62'd0, 1'b1, 1'b0});
    // same stream ending in 13 -> ERROR, word already written
    wa_q.delete();
    wd_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    tick();
    check("chk_bad_error", {61'd0, error, done, cpu_enable}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("chk_bad_writes", 64'(wa_q.size()), 64'd1);
    if (wa_q.size() > 0) check("chk_bad_word", {wa_q[0][31:0], wd_q[0]}, {32'h0, 32'h13});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
